// File: rtl/latch_capture_reader.sv
// Captures the value held on a level-sensitive latch interface into the clk domain and flags
// unstable closes. Optional 2-flop input synchronizers are enabled with LATCH_RD_SYNC_EN.
module latch_capture_reader #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic             glitch,
    output logic             busy,
    output logic [CNT_W-1:0] update_cnt
);

    // Sized so that STABLE_CYCLES-1 always fits, including STABLE_CYCLES == 1.
    localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
    localparam logic [SW-1:0] StabLast = SW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StOpen,
        StStable
    } state_e;

    logic [WIDTH-1:0] d_s;
    logic             en_s;

`ifdef LATCH_RD_SYNC_EN
    logic [WIDTH-1:0] d_m_d, d_m_q, d_s_d, d_s_q;
    logic             en_m_d, en_m_q, en_s_d, en_s_q;

    always_comb begin
        d_m_d  = d;
        d_s_d  = d_m_q;
        en_m_d = en;
        en_s_d = en_m_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_m_q  <= '0;
            d_s_q  <= '0;
            en_m_q <= 1'b0;
            en_s_q <= 1'b0;
        end else begin
            d_m_q  <= d_m_d;
            d_s_q  <= d_s_d;
            en_m_q <= en_m_d;
            en_s_q <= en_s_d;
        end
    end

    assign d_s  = d_s_q;
    assign en_s = en_s_q;
`else
    assign d_s  = d;
    assign en_s = en;
`endif

    state_e           state_d, state_q;
    logic [WIDTH-1:0] shadow_d, shadow_q;
    logic [SW-1:0]    stab_d, stab_q;
    logic [WIDTH-1:0] q_d, q_q;
    logic             q_valid_d, q_valid_q;
    logic             glitch_d, glitch_q;
    logic             busy_d, busy_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        stab_d    = stab_q;
        q_d       = q_q;
        q_valid_d = 1'b0;
        glitch_d  = 1'b0;
        cnt_d     = cnt_q;

        case (state_q)
            StIdle: begin
                if (en_s) begin
                    state_d  = StOpen;
                    shadow_d = d_s;
                    stab_d   = '0;
                end
            end
            StOpen: begin
                // A close always takes priority over a data change on the same edge.
                if (!en_s) begin
                    state_d  = StIdle;
                    glitch_d = 1'b1;
                end else if (d_s != shadow_q) begin
                    shadow_d = d_s;
                    stab_d   = '0;
                end else if (stab_q == StabLast) begin
                    state_d = StStable;
                end else begin
                    stab_d = stab_q + SW'(1);
                end
            end
            StStable: begin
                if (!en_s) begin
                    state_d   = StIdle;
                    q_d       = shadow_q;
                    q_valid_d = 1'b1;
                    cnt_d     = cnt_q + CNT_W'(1);
                end else if (d_s != shadow_q) begin
                    state_d  = StOpen;
                    shadow_d = d_s;
                    stab_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            shadow_q  <= '0;
            stab_q    <= '0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
            glitch_q  <= 1'b0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            stab_q    <= stab_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            glitch_q  <= glitch_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
        end
    end

    assign q          = q_q;
    assign q_valid    = q_valid_q;
    assign glitch     = glitch_q;
    assign busy       = busy_q;
    assign update_cnt = cnt_q;

endmodule

// File: tb/tb_latch_capture_reader.sv
// Self-checking bench for latch_capture_reader: a run-length model checked every cycle plus
// directed writes with literal expectations. Honours LATCH_RD_SYNC_EN for the input latency.
module tb_latch_capture_reader;

    localparam int unsigned STABLE_CYCLES = 4;
`ifdef LATCH_RD_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] d;
    logic       en;
    logic [7:0] q;
    logic       q_valid;
    logic       glitch;
    logic       busy;
    logic [7:0] update_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    latch_capture_reader #(
        .WIDTH        (8),
        .STABLE_CYCLES(STABLE_CYCLES),
        .CNT_W        (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .d         (d),
        .en        (en),
        .q         (q),
        .q_valid   (q_valid),
        .glitch    (glitch),
        .busy      (busy),
        .update_cnt(update_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Inputs as seen by the DUT at each rising edge.
    logic       s_rst, s_en;
    logic [7:0] s_d;
    always @(posedge clk) begin
        s_rst <= rst_n;
        s_en  <= en;
        s_d   <= d;
    end

    // Model: a close commits only if the held value was seen on at least STABLE_CYCLES+1
    // consecutive open edges; otherwise it is a glitch.
    logic       e1 = 1'b0, e2 = 1'b0;
    logic [7:0] dh1 = '0, dh2 = '0;
    bit         m_open = 0;
    logic [7:0] m_val = '0;
    int         m_run = 0;
    logic [7:0] m_q = '0;
    logic [7:0] m_cnt = '0;
    bit         m_qv = 0, m_gl = 0;

    task automatic model_step();
        logic       en_s;
        logic [7:0] d_s;
        if (LAT == 2) begin
            en_s = e2;
            d_s  = dh2;
            e2   = e1;
            dh2  = dh1;
            e1   = s_en;
            dh1  = s_d;
        end else begin
            en_s = s_en;
            d_s  = s_d;
        end
        m_qv = 0;
        m_gl = 0;
        if (!s_rst) begin
            e1 = 1'b0; e2 = 1'b0; dh1 = '0; dh2 = '0;
            m_open = 0; m_val = '0; m_run = 0; m_q = '0; m_cnt = '0;
        end else if (!m_open) begin
            if (en_s) begin
                m_open = 1;
                m_val  = d_s;
                m_run  = 1;
            end
        end else if (!en_s) begin
            m_open = 0;
            if (m_run >= int'(STABLE_CYCLES) + 1) begin
                m_q   = m_val;
                m_cnt = m_cnt + 8'd1;
                m_qv  = 1;
            end else begin
                m_gl = 1;
            end
        end else if (d_s != m_val) begin
            m_val = d_s;
            m_run = 1;
        end else if (m_run < 1000) begin
            m_run++;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            model_step();
            chk("q", 32'(q), 32'(m_q));
            chk("q_valid", 32'(q_valid), 32'(m_qv));
            chk("glitch", 32'(glitch), 32'(m_gl));
            chk("busy", 32'(busy), 32'(m_open));
            chk("update_cnt", 32'(update_cnt), 32'(m_cnt));
        end
    end

    task automatic hold(input int n);
        repeat (n) begin
            @(posedge clk);
            #3;
        end
    endtask

    // Open with v1 for n1 edges, then v2 for n2 edges, then close driving vc; observe the
    // following edges for pulses.
    task automatic do_write(input logic [7:0] v1, input int n1, input logic [7:0] v2,
                            input int n2, input logic [7:0] vc,
                            output int lat, output int nv, output int ng);
        en = 1'b1;
        d  = v1;
        hold(n1);
        d = v2;
        hold(n2);
        en  = 1'b0;
        d   = vc;
        lat = -1;
        nv  = 0;
        ng  = 0;
        for (int i = 0; i < LAT + 4; i++) begin
            @(posedge clk);
            #3;
            if (q_valid === 1'b1) begin
                nv++;
                if (lat < 0) lat = i;
            end
            if (glitch === 1'b1) ng++;
        end
    endtask

    int lat, nv, ng;

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        d     = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #3;
            chk("rst_q", 32'(q), 32'h0);
            chk("rst_q_valid", 32'(q_valid), 32'h0);
            chk("rst_glitch", 32'(glitch), 32'h0);
            chk("rst_busy", 32'(busy), 32'h0);
            chk("rst_cnt", 32'(update_cnt), 32'h0);
        end
        rst_n = 1'b1;
        en    = 1'b0;
        d     = 8'h00;
        hold(LAT + 2);

        do_write(8'hA5, 6, 8'hA5, 0, 8'hA5, lat, nv, ng);
        chk("clean_latency", 32'(lat), 32'(LAT));
        chk("clean_pulses", 32'(nv), 32'd1);
        chk("clean_no_glitch", 32'(ng), 32'd0);
        chk("clean_q", 32'(q), 32'hA5);
        chk("clean_cnt", 32'(update_cnt), 32'd1);

        do_write(8'h3C, 3, 8'h3C, 0, 8'h3C, lat, nv, ng);
        chk("short_glitch", 32'(ng), 32'd1);
        chk("short_no_valid", 32'(nv), 32'd0);
        chk("short_q", 32'(q), 32'hA5);
        chk("short_cnt", 32'(update_cnt), 32'd1);

        do_write(8'h11, 5, 8'h22, 5, 8'h22, lat, nv, ng);
        chk("change_pulses", 32'(nv), 32'd1);
        chk("change_q", 32'(q), 32'h22);
        chk("change_cnt", 32'(update_cnt), 32'd2);

        do_write(8'h22, 6, 8'h22, 0, 8'h33, lat, nv, ng);
        chk("simul_pulses", 32'(nv), 32'd1);
        chk("simul_q", 32'(q), 32'h22);
        chk("simul_cnt", 32'(update_cnt), 32'd3);

        // Minimum open time: one edge short must glitch.
        do_write(8'h5C, 4, 8'h5C, 0, 8'h5C, lat, nv, ng);
        chk("min_minus1_glitch", 32'(ng), 32'd1);
        do_write(8'h5C, 5, 8'h5C, 0, 8'h5C, lat, nv, ng);
        chk("min_accept", 32'(nv), 32'd1);
        chk("min_q", 32'(q), 32'h5C);

        // Reset while the latch is held stable.
        en = 1'b1;
        d  = 8'h5A;
        hold(6 + LAT);
        chk("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        hold(2);
        chk("mid_rst_q", 32'(q), 32'h0);
        chk("mid_rst_valid", 32'(q_valid), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_cnt", 32'(update_cnt), 32'h0);
        rst_n = 1'b1;
        en    = 1'b0;
        hold(LAT + 3);

        for (int i = 0; i < 256; i++) begin
            do_write(8'(i), 6, 8'(i), 0, 8'(i), lat, nv, ng);
            if (i == 254) chk("wrap_cnt_255", 32'(update_cnt), 32'd255);
        end
        chk("wrap_cnt_0", 32'(update_cnt), 32'd0);
        chk("wrap_q", 32'(q), 32'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/latch_capture_reader.md
# latch_capture_reader

Clocked reader for the level-sensitive latch write interface (`d`, `en`). A writer opens the latch with `en=1`, drives `d`, then closes it. This block captures the value present at the close into its `clk` domain and presents it as a registered word with a one-cycle `q_valid` strobe. It rejects writes whose data was not stable long enough before the close, and counts accepted updates.

## Interface
- `WIDTH`, 8: data width of `d`/`q`.
- `STABLE_CYCLES`, 4: consecutive clock edges `d` must stay constant while open before a close is accepted. Must be ≥1.
- `CNT_W`, 8: width of the update counter.

- `clk` input 1: the only clock. All state updates on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `d` input WIDTH: latch data from the writer. May be asynchronous to `clk`.
- `en` input 1: latch enable from the writer (1 = open, 0 = closed). May be asynchronous.
- `q` output WIDTH: last committed value.
- `q_valid` output 1: one-cycle pulse when `q` is updated.
- `glitch` output 1: one-cycle pulse when a close is rejected as unstable.
- `busy` output 1: high whenever the FSM is not in IDLE.
- `update_cnt` output CNT_W: number of committed updates, modulo 2^CNT_W.

## Operation
- **Input stage.** `d_s`/`en_s` are the conditioned inputs (see Configuration).
- **Reset** (`rst_n=0` at an edge):
  - state=IDLE.
  - `q`=0, `q_valid`=0, `glitch`=0, `busy`=0, `update_cnt`=0.
  - shadow=0, stab_cnt=0, synchronizer flops=0.
  - Reset mid-write aborts the write with no `q_valid` and no `glitch`.
- **Registers.** shadow[WIDTH] holds the candidate value; stab_cnt counts consecutive edges with `d_s`==shadow.
- **IDLE:**
  - `en_s=1` → OPEN, shadow←`d_s`, stab_cnt←0.
  - Otherwise hold; `q` is unchanged.
- **OPEN:**
  - `en_s=0` → IDLE, `glitch`=1 for one cycle, `q` unchanged.
  - Else if `d_s`≠shadow → shadow←`d_s`, stab_cnt←0, stay in OPEN.
  - Else if stab_cnt==STABLE_CYCLES-1 → STABLE.
  - Else stab_cnt←stab_cnt+1.
- **STABLE:**
  - `en_s=0` → commit: `q`←shadow, `q_valid`=1 for one cycle, `update_cnt`←`update_cnt`+1, → IDLE.
  - Else if `d_s`≠shadow → OPEN, shadow←`d_s`, stab_cnt←0.
  - Else hold.
- **Simultaneous events:**
  - In STABLE, `en_s` falling wins over a `d_s` change on the same edge: shadow (the stable value) is committed and the late `d_s` is ignored.
  - In OPEN, `en_s` falling wins: the close is a glitch.
- **Counter wrap.** `update_cnt` wraps from 2^CNT_W−1 to 0 silently.
- **Pulses.** `q_valid` and `glitch` are never high in the same cycle. Neither is ever high for more than one cycle per close.
- **Busy.** `busy` = (state≠IDLE), registered with the state.

## Timing
- **Minimum accepted open time.** `en_s` high on STABLE_CYCLES+1 consecutive edges (entry edge plus STABLE_CYCLES stable edges) with `d_s` constant. The close is then seen on the following edge.
- **Latency with LATCH_RD_SYNC_EN.**
  - `en` low first sampled at edge k → `q`/`q_valid` update at edge k+2.
  - `en` high sampled at edge k → `busy` at edge k+2.
- **Latency without LATCH_RD_SYNC_EN.** `en` low sampled at edge k → `q`/`q_valid` update at edge k.
- **Pulse width.** `q_valid`/`glitch` are high for exactly one clock period.
- **Back-to-back writes.** A new open may be accepted on the edge immediately after a commit, since IDLE is re-entered at the commit edge.

## Configuration
- `LATCH_RD_SYNC_EN` defined:
  - `d` and `en` each pass through a 2-flop synchronizer (reset to 0).
  - `d_s`/`en_s` are the second-stage outputs; adds 2 cycles of latency.
- Not defined:
  - `d_s`=`d`, `en_s`=`en` directly, with no added flops.
  - Use only when the writer is already synchronous to `clk`.

## Test plan
- **Reset:** `rst_n=0` for 2 cycles with `en=1`, `d`=8'hFF → `q`=0, `q_valid`=0, `glitch`=0, `busy`=0, `update_cnt`=0 throughout.
- **Clean write:** `en=1` for 6 cycles, `d`=8'hA5 constant, then `en=0` → single `q_valid` pulse with `q`=8'hA5, `update_cnt`=1. Check latency per macro setting.
- **Short write:** `en=1` for 3 cycles, `d`=8'h3C, then close → `glitch` pulse, `q` keeps its previous value, `update_cnt` unchanged.
- **Data change while open:** `d`=8'h11 for 5 cycles, then 8'h22 for 5 cycles, then close → `q`=8'h22. In a second run, `d` changes to 8'h33 on the same edge `en_s` falls while in STABLE → `q`=8'h22.
- **Wrap and reset mid-write:**
  - 256 clean writes with CNT_W=8 → `update_cnt` returns to 0.
  - Assert `rst_n=0` while in STABLE → no `q_valid`, `q`=0, state IDLE.
